// File: rtl/enc_message_buffer_pkg.sv
// Shared encoder constants and symbol type for the message buffer slice.
// Also provides the window-overflow test used by the top level.
package enc_message_buffer_pkg;

  localparam int RSC_SYM_WID     = 8;
  localparam int ENC_SYM         = 16;
  localparam int ENC_MES_BUF_DEP = 32;

  localparam int REQ_W  = $clog2(ENC_SYM + 1);
  localparam int OFF_W  = $clog2(ENC_MES_BUF_DEP + 1);
  // One bit beyond the nominal range so an out-of-range offset input can never alias back into the buffer
  localparam int IDX_W  = $clog2(ENC_MES_BUF_DEP + ENC_SYM + 1) + 1;
  localparam int BUF_AW = $clog2(ENC_MES_BUF_DEP);

  typedef logic [RSC_SYM_WID-1:0] RSC_SYM;

  function automatic logic win_overflow(input logic [OFF_W-1:0] off,
                                        input logic [REQ_W-1:0] req);
    logic [IDX_W-1:0] win_end;
    win_end = IDX_W'(off) + IDX_W'(ENC_SYM);
    return (req != '0) && (win_end > IDX_W'(ENC_MES_BUF_DEP));
  endfunction

endpackage

// File: rtl/enc_window_extract.sv
// Extracts an ENC_SYM-symbol window from the message buffer at a given offset.
// Lanes past the request count or past the buffer end read as zero.
module enc_window_extract
  import enc_message_buffer_pkg::*;
(
  input  RSC_SYM [ENC_MES_BUF_DEP-1:0]       buf_data,
  input  logic   [OFF_W-1:0]                 offset,
  input  logic   [REQ_W-1:0]                 request,
  output logic   [ENC_SYM*RSC_SYM_WID-1:0]   win
);

  for (genvar k = 0; k < ENC_SYM; k++) begin : g_lane
    logic [IDX_W-1:0] idx;
    logic             lane_en;

    // Lane 0 maps to the oldest symbol of the window
    assign idx     = IDX_W'(offset) + IDX_W'(ENC_SYM - 1 - k);
    assign lane_en = (REQ_W'(k) < request) && (idx < IDX_W'(ENC_MES_BUF_DEP));
    assign win[k*RSC_SYM_WID +: RSC_SYM_WID] = lane_en ? buf_data[idx[BUF_AW-1:0]] : '0;
  end

endmodule

// File: rtl/enc_message_buffer.sv
// Sliding-window message buffer feeding the parity processor and output selector.
// Holds the symbol shift register, registered read windows and sticky error flags.
module enc_message_buffer
  import enc_message_buffer_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [ENC_SYM*RSC_SYM_WID-1:0]   in_data,
  output logic                             in_ready,
  input  logic                             con_stall,
  input  logic [REQ_W-1:0]                 pro_request,
  input  logic [OFF_W-1:0]                 pro_offset,
  input  logic [REQ_W-1:0]                 mes_request,
  input  logic [OFF_W-1:0]                 mes_offset,
  output logic [ENC_SYM*RSC_SYM_WID-1:0]   pro_data,
  output logic                             pro_valid,
  output logic [ENC_SYM*RSC_SYM_WID-1:0]   mes_data,
  output logic                             mes_valid,
  output logic                             ovf_err,
  output logic                             udr_err
);

  RSC_SYM [ENC_MES_BUF_DEP-1:0]       mes_buf;
  logic   [ENC_SYM*RSC_SYM_WID-1:0]   pro_win;
  logic   [ENC_SYM*RSC_SYM_WID-1:0]   mes_win;

  assign in_ready = !con_stall;

  enc_window_extract u_pro_win (
    .buf_data (mes_buf),
    .offset   (pro_offset),
    .request  (pro_request),
    .win      (pro_win)
  );

  enc_window_extract u_mes_win (
    .buf_data (mes_buf),
    .offset   (mes_offset),
    .request  (mes_request),
    .win      (mes_win)
  );

  // Windows are taken from the pre-shift buffer, so a beat shows up one cycle after it is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mes_buf   <= '0;
      pro_data  <= '0;
      mes_data  <= '0;
      pro_valid <= 1'b0;
      mes_valid <= 1'b0;
      ovf_err   <= 1'b0;
      udr_err   <= 1'b0;
    end else begin
      if (in_ready) begin
        for (int i = ENC_SYM; i < ENC_MES_BUF_DEP; i++) begin
          mes_buf[i] <= mes_buf[i-ENC_SYM];
        end
        for (int k = 0; k < ENC_SYM; k++) begin
          mes_buf[ENC_SYM-1-k] <= in_valid ? in_data[k*RSC_SYM_WID +: RSC_SYM_WID] : '0;
        end
        if (!in_valid) udr_err <= 1'b1;
      end
      pro_data  <= pro_win;
      mes_data  <= mes_win;
      pro_valid <= (pro_request != '0);
      mes_valid <= (mes_request != '0);
      if (win_overflow(pro_offset, pro_request) || win_overflow(mes_offset, mes_request))
        ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_enc_message_buffer.sv
// Scoreboard bench for enc_message_buffer: the driver queues expected windows,
// a negedge monitor pops and compares whenever a valid window is presented.
module tb_enc_message_buffer;
  import enc_message_buffer_pkg::*;

  localparam int S   = ENC_SYM;
  localparam int W   = RSC_SYM_WID;
  localparam int DEP = ENC_MES_BUF_DEP;
  localparam int DW  = S * W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             in_ready;
  logic             con_stall = 1'b0;
  logic [REQ_W-1:0] pro_request = '0;
  logic [OFF_W-1:0] pro_offset = '0;
  logic [REQ_W-1:0] mes_request = '0;
  logic [OFF_W-1:0] mes_offset = '0;
  logic [DW-1:0]    pro_data;
  logic             pro_valid;
  logic [DW-1:0]    mes_data;
  logic             mes_valid;
  logic             ovf_err;
  logic             udr_err;

  enc_message_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .con_stall   (con_stall),
    .pro_request (pro_request),
    .pro_offset  (pro_offset),
    .mes_request (mes_request),
    .mes_offset  (mes_offset),
    .pro_data    (pro_data),
    .pro_valid   (pro_valid),
    .mes_data    (mes_data),
    .mes_valid   (mes_valid),
    .ovf_err     (ovf_err),
    .udr_err     (udr_err)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] pro_q[$];
  logic [DW-1:0] mes_q[$];
  logic [W-1:0]  mdl[DEP];
  logic          exp_ovf = 1'b0;
  logic          exp_udr = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input int base);
    logic [DW-1:0] v;
    for (int k = 0; k < S; k++) v[k*W +: W] = W'((base + k) % 256);
    return v;
  endfunction

  function automatic logic [DW-1:0] model_win(input int off, input int req);
    logic [DW-1:0] v;
    int idx;
    v = '0;
    for (int k = 0; k < S; k++) begin
      idx = off + S - 1 - k;
      if (k < req && idx < DEP) v[k*W +: W] = mdl[idx];
    end
    return v;
  endfunction

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic st,
                       input int preq, input int poff, input int mreq, input int moff,
                       input string tag);
    in_valid    = v;
    in_data     = d;
    con_stall   = st;
    pro_request = REQ_W'(preq);
    pro_offset  = OFF_W'(poff);
    mes_request = REQ_W'(mreq);
    mes_offset  = OFF_W'(moff);
    if (preq != 0) pro_q.push_back(model_win(poff, preq));
    if (mreq != 0) mes_q.push_back(model_win(moff, mreq));
    if ((preq != 0 && poff + S > DEP) || (mreq != 0 && moff + S > DEP)) exp_ovf = 1'b1;
    if (!st) begin
      for (int i = DEP - 1; i >= S; i--) mdl[i] = mdl[i-S];
      for (int k = 0; k < S; k++) mdl[S-1-k] = v ? d[k*W +: W] : '0;
      if (!v) exp_udr = 1'b1;
    end
    #1;
    chk({tag, " in_ready"}, DW'(in_ready), DW'(!st));
    @(posedge clk);
    #1;
    chk({tag, " ovf_err"}, DW'(ovf_err), DW'(exp_ovf));
    chk({tag, " udr_err"}, DW'(udr_err), DW'(exp_udr));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " pro_valid"}, DW'(pro_valid), '0);
    chk({tag, " mes_valid"}, DW'(mes_valid), '0);
    chk({tag, " pro_data"}, pro_data, '0);
    chk({tag, " mes_data"}, mes_data, '0);
    chk({tag, " ovf_err"}, DW'(ovf_err), '0);
    chk({tag, " udr_err"}, DW'(udr_err), '0);
    chk({tag, " in_ready"}, DW'(in_ready), DW'(1'b1));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pro_valid) begin
        if (pro_q.size() == 0) chk("pro unexpected valid", DW'(pro_valid), '0);
        else chk("pro window", pro_data, pro_q.pop_front());
      end
      if (mes_valid) begin
        if (mes_q.size() == 0) chk("mes unexpected valid", DW'(mes_valid), '0);
        else chk("mes window", mes_data, mes_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEP; i++) mdl[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;

    cycle(1'b1, beat(0),   1'b0,  0, 0,  0,  0, "beat0");
    cycle(1'b1, beat(16),  1'b0, 15, 1,  0,  0, "partial");
    cycle(1'b1, beat(32),  1'b0,  0, 0, 16,  0, "continuous");
    cycle(1'b1, beat(48),  1'b1, 16, 0, 16, 16, "stall");
    cycle(1'b1, beat(48),  1'b0, 16, 0, 16, 16, "after_stall");
    cycle(1'b1, beat(64),  1'b0, 16, 0, 16, 16, "post_stall");
    cycle(1'b1, beat(80),  1'b0,  8, 4,  0,  0, "mid_window");
    cycle(1'b1, beat(96),  1'b0,  0, 0, 16, 16, "ovf_boundary");
    cycle(1'b1, beat(112), 1'b0, 16, 20, 1, 17, "overflow");
    cycle(1'b0, '0,        1'b0, 16, 0,  0,  0, "underrun");
    cycle(1'b1, beat(128), 1'b0, 16, 0,  0,  0, "after_underrun");
    cycle(1'b1, beat(144), 1'b0,  0, 0,  0,  0, "zero_request");
    cycle(1'b1, beat(160), 1'b0,  0, 0,  0,  0, "idle");

    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("mid_reset");
    for (int i = 0; i < DEP; i++) mdl[i] = '0;
    exp_ovf = 1'b0;
    exp_udr = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cycle(1'b1, beat(200), 1'b0, 16, 0, 16, 16, "post_reset_empty");
    cycle(1'b1, beat(216), 1'b0, 16, 0,  0,  0, "post_reset_beat");
    repeat (3) cycle(1'b1, beat(232), 1'b0, 0, 0, 0, 0, "drain");

    chk("pro queue drained", DW'(pro_q.size()), '0);
    chk("mes queue drained", DW'(mes_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
